svm_cfg_regfile: RTL and testbench
==================================

# svm_cfg_regfile

Parametrised configuration register file for the SVM core. It replaces hard-wired configuration with a host-writable, lockable register map. The map carries a per-dimension base-pointer array, a sticky completion status and error capture. It sits between the host configuration port and the training/inference datapath, whose control fields it drives directly.

## Interface
Parameters:
- NUM_DIM_PTRS, 4: number of DIM_BASE_PTR registers (1..64).
- DATA_W, 32: register and bus width.
- ADDR_W, 16: word-address width.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, synchronous, active-low
- cfg_req_vld  in  1  host request valid
- cfg_req_rdy  out  1  request accepted when vld&rdy
- cfg_wr  in  1  1 = write, 0 = read
- cfg_addr  in  ADDR_W  word address
- cfg_wdata  in  DATA_W  write data
- cfg_rd_vld  out  1  one-cycle read-response strobe
- cfg_rd_data  out  DATA_W  read data, valid with cfg_rd_vld
- batch_comp_done  in  1  datapath completion pulse
- op_mode  out  2  reg0[1:0]
- data_type  out  3  reg1[2:0]
- auto_split, train_data_base, test_data_base, train_algo, num_dim, num_data_points, mode_dataset_org  out  DATA_W each  regs 2..8
- infer_res_base_ptr, weights_base_addr, infer_res_blk_size  out  DATA_W each  regs 12..14
- dim_base_ptr  out  NUM_DIM_PTRS*DATA_W  regs 16.. packed, ptr i at [i*DATA_W +: DATA_W]
- cfg_done  out  1  configuration committed/locked (reg9 bit0)
- comp_done  out  1  sticky completion (reg10 bit0)
- cfg_err  out  3  sticky error flags (reg11[2:0])

## Operation
- Map (word addr, reset value):
  - 0 OP_MODE = 2
  - 1 DATA_TYPE = 2
  - 2 AUTO_SPLIT = 0x3E4CCCCD
  - 3 TRAIN_DATA_BASE = 0
  - 4 TEST_DATA_BASE = 0
  - 5 TRAIN_ALGO = 1
  - 6 NUM_DIM = 2
  - 7 NUM_DATA_POINTS = 12
  - 8 MODE_DATASET_ORG = 2
  - 9 CTRL = 0
  - 10 STATUS = 0
  - 11 ERR = 0
  - 12 INFER_RES_BASE_PTR = 0x200
  - 13 WEIGHTS_BASE_ADDR = 96
  - 14 INFER_RES_BLK_SIZE = 1
  - 15 reserved, reads 0
  - 16..16+NUM_DIM_PTRS-1 DIM_BASE_PTR[i] = 0
- Fields narrower than DATA_W store only their bits; unused bits read 0.
- Writes to config regs (0–8, 12–14, DIM_BASE_PTR):
  - accepted only while cfg_done=0;
  - while cfg_done=1 they are dropped and set ERR[0] (write-while-locked).
- CTRL (9) write:
  - bit1=1 clears cfg_done (unlock); bit1 takes priority over bit0.
  - else bit0=1 commits: if 1 ≤ NUM_DIM ≤ NUM_DIM_PTRS, set cfg_done; otherwise set ERR[2] and leave cfg_done=0.
  - CTRL is always writable.
- STATUS (10) is write-1-to-clear on bit0. batch_comp_done=1 sets bit0. If set and clear occur in the same cycle, set wins.
- ERR (11) is write-1-to-clear per bit. A same-cycle new error wins over its clear.
- Out-of-range address (reserved 15 or ≥ 16+NUM_DIM_PTRS):
  - write: no effect, sets ERR[1];
  - read: returns 0, sets ERR[1].
- Reads never modify state, except ERR[1] on a bad address.

## Timing
- Reset (rst_n=0 at a clk edge): all regs take their map values. cfg_req_rdy=1, cfg_rd_vld=0, cfg_rd_data=0, cfg_done=0, comp_done=0, cfg_err=0.
- Handshake:
  - cfg_req_rdy = !rd_pending, so at most one read is outstanding.
  - Writes never deassert rdy; back-to-back writes are accepted every cycle.
- Write accepted at edge N: register and output ports show the new value after edge N. CTRL commit and cfg_done update at that edge.
- Read accepted at edge N:
  - cfg_rd_vld=1 and cfg_rd_data valid for exactly the cycle after edge N; rdy=0 in that cycle.
  - Read data is the value before any same-edge internal update (e.g. batch_comp_done at edge N is not visible).
  - cfg_rd_data returns to 0 when cfg_rd_vld=0.
- Throughput: reads 1 per 2 cycles, writes 1 per cycle.
- batch_comp_done sampled at edge N: comp_done=1 after edge N.
- Reset mid-read: the pending response is discarded; cfg_rd_vld=0 after the reset edge.

## Test plan
- Reset, then read addrs 0..14 -> each cfg_rd_vld response matches the reset map (e.g. addr2 -> 0x3E4CCCCD, addr13 -> 96); addr 16 -> 0.
- Write DIM_BASE_PTR[3]=0x1000 (NUM_DIM_PTRS=4), NUM_DIM=4, CTRL=1 -> dim_base_ptr[127:96]=0x1000, cfg_done=1 on the next cycle; ERR=0.
- With cfg_done=1, write addr3=0xABC -> train_data_base unchanged, ERR=1. Write CTRL=2 -> cfg_done=0. Repeat the addr3 write -> 0xABC.
- NUM_DIM=5 with NUM_DIM_PTRS=4, then CTRL=1 -> cfg_done stays 0, ERR[2]=1. Write ERR=4 -> cfg_err=0.
- Pulse batch_comp_done in the same cycle as a STATUS write of 1 -> comp_done=1. Next STATUS write of 1 -> comp_done=0.
- Read addr 20 -> rd_data 0, ERR[1]=1. Hold cfg_req_vld continuously for reads -> rdy alternates 1/0 and responses arrive every second cycle. Assert reset during a pending read -> no cfg_rd_vld.

Source files
------------

// File: rtl/svm_cfg_regfile.sv
// Host-writable, lockable configuration register file for the SVM core.
// Drives datapath control fields and tracks completion status and errors.
module svm_cfg_regfile #(
  parameter int unsigned NUM_DIM_PTRS = 4,
  parameter int unsigned DATA_W       = 32,
  parameter int unsigned ADDR_W       = 16
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             cfg_req_vld,
  output logic                             cfg_req_rdy,
  input  logic                             cfg_wr,
  input  logic [ADDR_W-1:0]                cfg_addr,
  input  logic [DATA_W-1:0]                cfg_wdata,
  output logic                             cfg_rd_vld,
  output logic [DATA_W-1:0]                cfg_rd_data,
  input  logic                             batch_comp_done,
  output logic [1:0]                       op_mode,
  output logic [2:0]                       data_type,
  output logic [DATA_W-1:0]                auto_split,
  output logic [DATA_W-1:0]                train_data_base,
  output logic [DATA_W-1:0]                test_data_base,
  output logic [DATA_W-1:0]                train_algo,
  output logic [DATA_W-1:0]                num_dim,
  output logic [DATA_W-1:0]                num_data_points,
  output logic [DATA_W-1:0]                mode_dataset_org,
  output logic [DATA_W-1:0]                infer_res_base_ptr,
  output logic [DATA_W-1:0]                weights_base_addr,
  output logic [DATA_W-1:0]                infer_res_blk_size,
  output logic [NUM_DIM_PTRS*DATA_W-1:0]   dim_base_ptr,
  output logic                             cfg_done,
  output logic                             comp_done,
  output logic [2:0]                       cfg_err
);

  localparam int unsigned IDX_W = (NUM_DIM_PTRS > 1) ? $clog2(NUM_DIM_PTRS) : 1;

  localparam logic [ADDR_W-1:0] A_OP_MODE     = ADDR_W'(0);
  localparam logic [ADDR_W-1:0] A_DATA_TYPE   = ADDR_W'(1);
  localparam logic [ADDR_W-1:0] A_AUTO_SPLIT  = ADDR_W'(2);
  localparam logic [ADDR_W-1:0] A_TRAIN_BASE  = ADDR_W'(3);
  localparam logic [ADDR_W-1:0] A_TEST_BASE   = ADDR_W'(4);
  localparam logic [ADDR_W-1:0] A_TRAIN_ALGO  = ADDR_W'(5);
  localparam logic [ADDR_W-1:0] A_NUM_DIM     = ADDR_W'(6);
  localparam logic [ADDR_W-1:0] A_NUM_POINTS  = ADDR_W'(7);
  localparam logic [ADDR_W-1:0] A_MODE_ORG    = ADDR_W'(8);
  localparam logic [ADDR_W-1:0] A_CTRL        = ADDR_W'(9);
  localparam logic [ADDR_W-1:0] A_STATUS      = ADDR_W'(10);
  localparam logic [ADDR_W-1:0] A_ERR         = ADDR_W'(11);
  localparam logic [ADDR_W-1:0] A_INFER_BASE  = ADDR_W'(12);
  localparam logic [ADDR_W-1:0] A_WEIGHTS     = ADDR_W'(13);
  localparam logic [ADDR_W-1:0] A_INFER_BLK   = ADDR_W'(14);
  localparam logic [ADDR_W-1:0] A_DIM_LO      = ADDR_W'(16);
  localparam logic [ADDR_W-1:0] A_DIM_END     = ADDR_W'(16 + NUM_DIM_PTRS);

  localparam logic [DATA_W-1:0] RST_AUTO_SPLIT = DATA_W'(32'h3E4C_CCCD);
  localparam logic [DATA_W-1:0] RST_INFER_BASE = DATA_W'(32'h0000_0200);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RESP = 1'b1
  } state_t;

  state_t              state;
  state_t              state_next;
  logic                rdy_next;
  logic                rd_vld_next;
  logic [DATA_W-1:0]   rd_data_next;

  logic [DATA_W-1:0]   dim_ptr [NUM_DIM_PTRS];
  logic [DATA_W-1:0]   rd_mux;

  logic                req_acc;
  logic                wr_acc;
  logic                rd_acc;
  logic                in_dim;
  logic                is_cfg;
  logic                is_ctrl;
  logic                is_status;
  logic                is_err;
  logic                is_bad;
  logic [IDX_W-1:0]    dim_idx;
  logic                num_dim_ok;
  logic                cfg_we;
  logic                ctrl_we;
  logic                status_clr;
  logic [2:0]          err_set;
  logic [2:0]          err_clr;

  // Handshake qualification and address classification
  always_comb begin
    req_acc    = cfg_req_vld & cfg_req_rdy;
    wr_acc     = req_acc & cfg_wr;
    rd_acc     = req_acc & ~cfg_wr;
    in_dim     = (cfg_addr >= A_DIM_LO) && (cfg_addr < A_DIM_END);
    dim_idx    = IDX_W'(cfg_addr - A_DIM_LO);
    is_ctrl    = (cfg_addr == A_CTRL);
    is_status  = (cfg_addr == A_STATUS);
    is_err     = (cfg_addr == A_ERR);
    is_cfg     = in_dim || (cfg_addr <= A_MODE_ORG) ||
                 ((cfg_addr >= A_INFER_BASE) && (cfg_addr <= A_INFER_BLK));
    is_bad     = !(is_cfg || is_ctrl || is_status || is_err);
    num_dim_ok = (num_dim != '0) && (num_dim <= DATA_W'(NUM_DIM_PTRS));
  end

  // Write enables and sticky error sources
  always_comb begin
    cfg_we     = wr_acc & is_cfg & ~cfg_done;
    ctrl_we    = wr_acc & is_ctrl;
    status_clr = wr_acc & is_status & cfg_wdata[0];
    err_clr    = (wr_acc & is_err) ? cfg_wdata[2:0] : 3'b000;
    err_set    = 3'b000;
    err_set[0] = wr_acc & is_cfg & cfg_done;
    err_set[1] = req_acc & is_bad;
    err_set[2] = ctrl_we & ~cfg_wdata[1] & cfg_wdata[0] & ~num_dim_ok;
  end

  // Read data mux; reserved and out-of-range addresses return zero
  always_comb begin
    rd_mux = '0;
    if (in_dim) begin
      rd_mux = dim_ptr[dim_idx];
    end else begin
      case (cfg_addr)
        A_OP_MODE:    rd_mux = DATA_W'(op_mode);
        A_DATA_TYPE:  rd_mux = DATA_W'(data_type);
        A_AUTO_SPLIT: rd_mux = auto_split;
        A_TRAIN_BASE: rd_mux = train_data_base;
        A_TEST_BASE:  rd_mux = test_data_base;
        A_TRAIN_ALGO: rd_mux = train_algo;
        A_NUM_DIM:    rd_mux = num_dim;
        A_NUM_POINTS: rd_mux = num_data_points;
        A_MODE_ORG:   rd_mux = mode_dataset_org;
        A_CTRL:       rd_mux = DATA_W'(cfg_done);
        A_STATUS:     rd_mux = DATA_W'(comp_done);
        A_ERR:        rd_mux = DATA_W'(cfg_err);
        A_INFER_BASE: rd_mux = infer_res_base_ptr;
        A_WEIGHTS:    rd_mux = weights_base_addr;
        A_INFER_BLK:  rd_mux = infer_res_blk_size;
        default:      rd_mux = '0;
      endcase
    end
  end

  // Read-response FSM state and registered handshake outputs
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      cfg_req_rdy <= 1'b1;
      cfg_rd_vld  <= 1'b0;
      cfg_rd_data <= '0;
    end else begin
      state       <= state_next;
      cfg_req_rdy <= rdy_next;
      cfg_rd_vld  <= rd_vld_next;
      cfg_rd_data <= rd_data_next;
    end
  end

  // One outstanding read: the response cycle blocks new requests
  always_comb begin
    state_next   = state;
    rd_vld_next  = 1'b0;
    rd_data_next = '0;
    case (state)
      ST_IDLE: begin
        if (rd_acc) begin
          state_next   = ST_RESP;
          rd_vld_next  = 1'b1;
          rd_data_next = rd_mux;
        end
      end
      ST_RESP: state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
    rdy_next = (state_next == ST_IDLE);
  end

  // Lockable configuration registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      op_mode            <= 2'd2;
      data_type          <= 3'd2;
      auto_split         <= RST_AUTO_SPLIT;
      train_data_base    <= '0;
      test_data_base     <= '0;
      train_algo         <= DATA_W'(1);
      num_dim            <= DATA_W'(2);
      num_data_points    <= DATA_W'(12);
      mode_dataset_org   <= DATA_W'(2);
      infer_res_base_ptr <= RST_INFER_BASE;
      weights_base_addr  <= DATA_W'(96);
      infer_res_blk_size <= DATA_W'(1);
      for (int i = 0; i < int'(NUM_DIM_PTRS); i++) begin
        dim_ptr[i] <= '0;
      end
    end else if (cfg_we) begin
      if (in_dim) begin
        dim_ptr[dim_idx] <= cfg_wdata;
      end else begin
        case (cfg_addr)
          A_OP_MODE:    op_mode            <= cfg_wdata[1:0];
          A_DATA_TYPE:  data_type          <= cfg_wdata[2:0];
          A_AUTO_SPLIT: auto_split         <= cfg_wdata;
          A_TRAIN_BASE: train_data_base    <= cfg_wdata;
          A_TEST_BASE:  test_data_base     <= cfg_wdata;
          A_TRAIN_ALGO: train_algo         <= cfg_wdata;
          A_NUM_DIM:    num_dim            <= cfg_wdata;
          A_NUM_POINTS: num_data_points    <= cfg_wdata;
          A_MODE_ORG:   mode_dataset_org   <= cfg_wdata;
          A_INFER_BASE: infer_res_base_ptr <= cfg_wdata;
          A_WEIGHTS:    weights_base_addr  <= cfg_wdata;
          A_INFER_BLK:  infer_res_blk_size <= cfg_wdata;
          default: ;
        endcase
      end
    end
  end

  // Lock, sticky completion and sticky errors; new events win over clears
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cfg_done  <= 1'b0;
      comp_done <= 1'b0;
      cfg_err   <= 3'b000;
    end else begin
      if (ctrl_we) begin
        if (cfg_wdata[1]) begin
          cfg_done <= 1'b0;
        end else if (cfg_wdata[0] && num_dim_ok) begin
          cfg_done <= 1'b1;
        end
      end
      comp_done <= batch_comp_done | (comp_done & ~status_clr);
      cfg_err   <= (cfg_err & ~err_clr) | err_set;
    end
  end

  always_comb begin
    dim_base_ptr = '0;
    for (int i = 0; i < int'(NUM_DIM_PTRS); i++) begin
      dim_base_ptr[i*DATA_W +: DATA_W] = dim_ptr[i];
    end
  end

endmodule

// File: tb/tb_svm_cfg_regfile.sv
// Self-checking bench for svm_cfg_regfile: directed scenarios plus randomized
// traffic checked against an address-indexed behavioural model.
module tb_svm_cfg_regfile;

  localparam int unsigned NP   = 4;
  localparam int unsigned DW   = 32;
  localparam int unsigned AW   = 16;
  localparam int unsigned NREG = 16 + NP;

  logic            clk;
  logic            rst_n;
  logic            cfg_req_vld;
  logic            cfg_req_rdy;
  logic            cfg_wr;
  logic [AW-1:0]   cfg_addr;
  logic [DW-1:0]   cfg_wdata;
  logic            cfg_rd_vld;
  logic [DW-1:0]   cfg_rd_data;
  logic            batch_comp_done;
  logic [1:0]      op_mode;
  logic [2:0]      data_type;
  logic [DW-1:0]   auto_split, train_data_base, test_data_base, train_algo;
  logic [DW-1:0]   num_dim, num_data_points, mode_dataset_org;
  logic [DW-1:0]   infer_res_base_ptr, weights_base_addr, infer_res_blk_size;
  logic [NP*DW-1:0] dim_base_ptr;
  logic            cfg_done;
  logic            comp_done;
  logic [2:0]      cfg_err;

  svm_cfg_regfile #(.NUM_DIM_PTRS(NP), .DATA_W(DW), .ADDR_W(AW)) dut (
    .clk(clk), .rst_n(rst_n),
    .cfg_req_vld(cfg_req_vld), .cfg_req_rdy(cfg_req_rdy), .cfg_wr(cfg_wr),
    .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata),
    .cfg_rd_vld(cfg_rd_vld), .cfg_rd_data(cfg_rd_data),
    .batch_comp_done(batch_comp_done),
    .op_mode(op_mode), .data_type(data_type), .auto_split(auto_split),
    .train_data_base(train_data_base), .test_data_base(test_data_base),
    .train_algo(train_algo), .num_dim(num_dim), .num_data_points(num_data_points),
    .mode_dataset_org(mode_dataset_org), .infer_res_base_ptr(infer_res_base_ptr),
    .weights_base_addr(weights_base_addr), .infer_res_blk_size(infer_res_blk_size),
    .dim_base_ptr(dim_base_ptr), .cfg_done(cfg_done), .comp_done(comp_done),
    .cfg_err(cfg_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  logic [31:0] rst_map [0:16] = '{32'd2, 32'd2, 32'h3E4C_CCCD, 32'd0, 32'd0, 32'd1,
                                  32'd2, 32'd12, 32'd2, 32'd0, 32'd0, 32'd0,
                                  32'h200, 32'd96, 32'd1, 32'd0, 32'd0};

  // Reference model state, indexed by word address
  logic [31:0] m_reg [0:NREG-1];
  bit          m_done, m_comp, m_rvld;
  logic [2:0]  m_err;
  logic [31:0] m_rdata;

  function automatic logic [31:0] fmask(input int unsigned a);
    if (a == 0) return 32'h3;
    if (a == 1) return 32'h7;
    return 32'hFFFF_FFFF;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < int'(NREG); i++) m_reg[i] = (i < 17) ? rst_map[i] : 32'd0;
    m_done = 0; m_comp = 0; m_rvld = 0; m_err = 3'b000; m_rdata = 32'd0;
  endtask

  // Drive one cycle of inputs, advance past the edge, update the model
  task automatic step(input bit vld, input bit wr, input int unsigned addr,
                      input logic [31:0] wdata, input bit bcd);
    bit acc, bad, n_done, n_comp, w_en;
    logic [31:0] rv, n_rdata;
    logic [2:0] set_e, clr_e;
    cfg_req_vld = vld; cfg_wr = wr; cfg_addr = 16'(addr);
    cfg_wdata = wdata; batch_comp_done = bcd;
    acc = vld && !m_rvld;
    bad = (addr == 15) || (addr >= NREG);
    rv = 32'd0;
    if (!bad) begin
      case (addr)
        9:  rv = {31'd0, m_done};
        10: rv = {31'd0, m_comp};
        11: rv = {29'd0, m_err};
        default: rv = m_reg[addr];
      endcase
    end
    n_rdata = (acc && !wr) ? rv : 32'd0;
    set_e = 3'b000; clr_e = 3'b000; n_done = m_done; w_en = 0;
    if (acc && bad) set_e[1] = 1'b1;
    if (acc && wr && !bad) begin
      if (addr == 9) begin
        if (wdata[1]) n_done = 0;
        else if (wdata[0]) begin
          if (m_reg[6] >= 1 && m_reg[6] <= NP) n_done = 1;
          else set_e[2] = 1'b1;
        end
      end else if (addr == 11) begin
        clr_e = wdata[2:0];
      end else if (addr != 10) begin
        if (m_done) set_e[0] = 1'b1;
        else w_en = 1;
      end
    end
    n_comp = bcd || (m_comp && !(acc && wr && addr == 10 && wdata[0]));
    @(posedge clk);
    #1;
    if (!rst_n) begin
      model_reset();
    end else begin
      if (w_en) m_reg[addr] = wdata & fmask(addr);
      m_done = n_done; m_comp = n_comp;
      m_err = (m_err & ~clr_e) | set_e;
      m_rvld = acc && !wr; m_rdata = n_rdata;
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    step(0, 0, 0, 32'd0, 0);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    n_vec++;
    if ({cfg_req_rdy, cfg_rd_vld, cfg_rd_data} !== {1'b1, 1'b0, 32'd0}) begin
      n_err++; $display("FAIL reset_hs got rdy=%b vld=%b data=%h exp 1 0 0", cfg_req_rdy, cfg_rd_vld, cfg_rd_data);
    end
    n_vec++;
    if ({cfg_done, comp_done, cfg_err} !== 5'b0) begin
      n_err++; $display("FAIL reset_status got %b%b%b exp 00000", cfg_done, comp_done, cfg_err);
    end
    n_vec++;
    if ({op_mode, data_type, auto_split, weights_base_addr, infer_res_base_ptr} !==
        {2'd2, 3'd2, 32'h3E4C_CCCD, 32'd96, 32'h200}) begin
      n_err++; $display("FAIL reset_fields got om=%h dt=%h as=%h wb=%h ib=%h", op_mode, data_type, auto_split, weights_base_addr, infer_res_base_ptr);
    end
  endtask

  task automatic test_reset_map();
    int unsigned a;
    for (int k = 0; k < 16; k++) begin
      a = (k == 15) ? 16 : k;
      step(1, 0, a, 32'd0, 0);
      n_vec++;
      if ({cfg_rd_vld, cfg_rd_data} !== {1'b1, rst_map[a]}) begin
        n_err++; $display("FAIL reset_map addr=%0d got vld=%b data=%h exp 1 %h", a, cfg_rd_vld, cfg_rd_data, rst_map[a]);
      end
      step(0, 0, 0, 32'd0, 0);
    end
  endtask

  task automatic test_commit();
    step(1, 1, 19, 32'h1000, 0);
    step(1, 1, 6, 32'd4, 0);
    step(1, 1, 9, 32'd1, 0);
    n_vec++;
    if ({dim_base_ptr[127:96], cfg_done, cfg_err} !== {32'h1000, 1'b1, 3'b000}) begin
      n_err++; $display("FAIL commit got ptr3=%h done=%b err=%b exp 1000 1 000", dim_base_ptr[127:96], cfg_done, cfg_err);
    end
  endtask

  task automatic test_lock();
    step(1, 1, 3, 32'hABC, 0);
    n_vec++;
    if ({train_data_base, cfg_err} !== {32'd0, 3'b001}) begin
      n_err++; $display("FAIL locked_write got tdb=%h err=%b exp 0 001", train_data_base, cfg_err);
    end
    step(1, 1, 9, 32'd2, 0);
    n_vec++;
    if (cfg_done !== 1'b0) begin
      n_err++; $display("FAIL unlock got done=%b exp 0", cfg_done);
    end
    step(1, 1, 3, 32'hABC, 0);
    n_vec++;
    if (train_data_base !== 32'hABC) begin
      n_err++; $display("FAIL unlocked_write got tdb=%h exp abc", train_data_base);
    end
    step(1, 1, 11, 32'd7, 0);
    n_vec++;
    if (cfg_err !== 3'b000) begin
      n_err++; $display("FAIL err_clear got %b exp 000", cfg_err);
    end
  endtask

  task automatic test_commit_err();
    step(1, 1, 6, 32'd5, 0);
    step(1, 1, 9, 32'd1, 0);
    n_vec++;
    if ({cfg_done, cfg_err} !== {1'b0, 3'b100}) begin
      n_err++; $display("FAIL bad_commit got done=%b err=%b exp 0 100", cfg_done, cfg_err);
    end
    step(1, 1, 11, 32'd4, 0);
    n_vec++;
    if (cfg_err !== 3'b000) begin
      n_err++; $display("FAIL err2_clear got %b exp 000", cfg_err);
    end
    step(1, 1, 6, 32'd0, 0);
    step(1, 1, 9, 32'd1, 0);
    n_vec++;
    if ({cfg_done, cfg_err} !== {1'b0, 3'b100}) begin
      n_err++; $display("FAIL zero_dim_commit got done=%b err=%b exp 0 100", cfg_done, cfg_err);
    end
    step(1, 1, 11, 32'd7, 0);
    step(1, 1, 6, 32'd2, 0);
  endtask

  task automatic test_status();
    step(1, 1, 10, 32'd1, 1);
    n_vec++;
    if (comp_done !== 1'b1) begin
      n_err++; $display("FAIL status_set_wins got %b exp 1", comp_done);
    end
    step(1, 1, 10, 32'd1, 0);
    n_vec++;
    if (comp_done !== 1'b0) begin
      n_err++; $display("FAIL status_w1c got %b exp 0", comp_done);
    end
    step(1, 0, 10, 32'd0, 1);
    n_vec++;
    if ({cfg_rd_vld, cfg_rd_data, comp_done} !== {1'b1, 32'd0, 1'b1}) begin
      n_err++; $display("FAIL status_read_pre got vld=%b data=%h comp=%b exp 1 0 1", cfg_rd_vld, cfg_rd_data, comp_done);
    end
    step(0, 0, 0, 32'd0, 0);
    step(1, 1, 10, 32'd1, 0);
  endtask

  task automatic test_bad_addr();
    step(1, 0, 20, 32'd0, 0);
    n_vec++;
    if ({cfg_rd_vld, cfg_rd_data, cfg_err} !== {1'b1, 32'd0, 3'b010}) begin
      n_err++; $display("FAIL bad_read got vld=%b data=%h err=%b exp 1 0 010", cfg_rd_vld, cfg_rd_data, cfg_err);
    end
    step(0, 0, 0, 32'd0, 0);
    step(1, 1, 11, 32'd2, 0);
    step(1, 1, 15, 32'hFFFF_FFFF, 0);
    n_vec++;
    if (cfg_err !== 3'b010) begin
      n_err++; $display("FAIL reserved_write got err=%b exp 010", cfg_err);
    end
    step(1, 1, 11, 32'd7, 0);
  endtask

  task automatic test_back_to_back();
    logic [31:0] d;
    for (int k = 0; k < 8; k++) begin
      step(1, 0, $urandom_range(0, 14), 32'd0, 0);
      n_vec++;
      if ({cfg_rd_vld, cfg_req_rdy, cfg_rd_data} !== {(k % 2) == 0, (k % 2) == 1, m_rdata}) begin
        n_err++; $display("FAIL b2b_read k=%0d got vld=%b rdy=%b data=%h exp vld=%b data=%h", k, cfg_rd_vld, cfg_req_rdy, cfg_rd_data, (k % 2) == 0, m_rdata);
      end
    end
    step(0, 0, 0, 32'd0, 0);
    for (int k = 0; k < 4; k++) begin
      d = $urandom;
      step(1, 1, 16 + k, d, 0);
      n_vec++;
      if ({cfg_req_rdy, dim_base_ptr[k*32 +: 32]} !== {1'b1, d}) begin
        n_err++; $display("FAIL b2b_write k=%0d got rdy=%b ptr=%h exp 1 %h", k, cfg_req_rdy, dim_base_ptr[k*32 +: 32], d);
      end
    end
  endtask

  task automatic test_reset_mid_read();
    step(1, 0, 2, 32'd0, 0);
    rst_n = 1'b0;
    step(1, 0, 5, 32'd0, 0);
    rst_n = 1'b1;
    n_vec++;
    if ({cfg_rd_vld, cfg_req_rdy, cfg_rd_data} !== {1'b0, 1'b1, 32'd0}) begin
      n_err++; $display("FAIL reset_mid_read got vld=%b rdy=%b data=%h exp 0 1 0", cfg_rd_vld, cfg_req_rdy, cfg_rd_data);
    end
    step(0, 0, 0, 32'd0, 0);
    n_vec++;
    if (cfg_rd_vld !== 1'b0) begin
      n_err++; $display("FAIL reset_no_resp got vld=%b exp 0", cfg_rd_vld);
    end
  endtask

  task automatic test_random();
    int unsigned a;
    logic [31:0] d;
    logic [491:0] act, exp;
    do_reset();
    for (int k = 0; k < 600; k++) begin
      a = ($urandom_range(0, 9) == 0) ? $urandom_range(15, 40) : $urandom_range(0, 19);
      d = $urandom;
      if (a == 6) d = $urandom_range(0, 6);
      if (a == 9) d = $urandom_range(0, 3);
      step($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1, a, d, $urandom_range(0, 7) == 0);
      act = {cfg_req_rdy, cfg_rd_vld, cfg_rd_data, op_mode, data_type, auto_split,
             train_data_base, test_data_base, train_algo, num_dim, num_data_points,
             mode_dataset_org, infer_res_base_ptr, weights_base_addr, infer_res_blk_size,
             dim_base_ptr, cfg_done, comp_done, cfg_err};
      exp = {!m_rvld, m_rvld, m_rdata, m_reg[0][1:0], m_reg[1][2:0], m_reg[2],
             m_reg[3], m_reg[4], m_reg[5], m_reg[6], m_reg[7],
             m_reg[8], m_reg[12], m_reg[13], m_reg[14],
             m_reg[19], m_reg[18], m_reg[17], m_reg[16], m_done, m_comp, m_err};
      n_vec++;
      if (act !== exp) begin
        n_err++; $display("FAIL random k=%0d got %h exp %h", k, act, exp);
      end
    end
  endtask

  initial begin
    rst_n = 1'b0; cfg_req_vld = 1'b0; cfg_wr = 1'b0; cfg_addr = '0;
    cfg_wdata = '0; batch_comp_done = 1'b0;
    model_reset();
    test_reset();
    test_reset_map();
    test_commit();
    test_lock();
    test_commit_err();
    test_status();
    test_bad_addr();
    test_back_to_back();
    test_reset_mid_read();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
